// File: rtl/conv_code_pkg.sv
// Shared constants, FSM encoding and branch-label function for the K=7 rate-1/3 tail-biting code.
package conv_code_pkg;
  localparam int K          = 7;
  localparam int STATE_W    = 6;
  localparam int NUM_STATES = 64;

  // Bit 6 multiplies the newest input u, bit 0 the oldest state bit s[0].
  localparam logic [K-1:0] G0 = 7'b1011011;
  localparam logic [K-1:0] G1 = 7'b1111001;
  localparam logic [K-1:0] G2 = 7'b1110101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META,
    ST_FETCH,
    ST_ACS,
    ST_TB,
    ST_EMIT
  } vit_state_t;

  // Coded triple {c2,c1,c0} emitted when input u is shifted into state s.
  function automatic logic [2:0] expected_triple(input logic u, input logic [STATE_W-1:0] s);
    logic [K-1:0] w;
    w = {u, s};
    return {^(G2 & w), ^(G1 & w), ^(G0 & w)};
  endfunction
endpackage

// File: rtl/vit_acs_unit.sv
// Branch metrics and compare-select for one next state; purely combinational.
module vit_acs_unit
  import conv_code_pkg::*;
#(
  parameter int PM_W = 14
) (
  input  logic [STATE_W-1:0] next_state,
  input  logic [2:0]         rx,
  input  logic [PM_W-1:0]    pm0,
  input  logic [PM_W-1:0]    pm1,
  output logic [PM_W-1:0]    pm_new,
  output logic               surv
);
  logic [2:0]      d0;
  logic [2:0]      d1;
  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    d0     = rx ^ expected_triple(next_state[5], {next_state[4:0], 1'b0});
    d1     = rx ^ expected_triple(next_state[5], {next_state[4:0], 1'b1});
    cand0  = pm0 + PM_W'(d0[0]) + PM_W'(d0[1]) + PM_W'(d0[2]);
    cand1  = pm1 + PM_W'(d1[0]) + PM_W'(d1[1]) + PM_W'(d1[2]);
    // Ties resolve to the p0 predecessor.
    surv   = (cand1 < cand0);
    pm_new = surv ? cand1 : cand0;
  end
endmodule

// File: rtl/conv_decoder_vit.sv
// Serial hard-decision Viterbi decoder for the tail-biting K=7 rate-1/3 block code.
// One trellis state per cycle, full-block survivor RAM, single traceback from the best end state.
module conv_decoder_vit
  import conv_code_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int PM_W      = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] meta_in,
  input  logic       meta_empty,
  output logic       meta_rdreq,
  input  logic [7:0] c0_in,
  input  logic [7:0] c1_in,
  input  logic [7:0] c2_in,
  input  logic [2:0] c_empty,
  output logic       c_rdreq,
  output logic [7:0] dec_out,
  output logic       dec_wrreq,
  input  logic       dec_full,
  output logic       busy,
  output logic       block_done,
  output logic       len_err
);
  localparam int STEPS = 8 * MAX_BYTES;
  localparam int T_W   = $clog2(STEPS);
  localparam int B_W   = $clog2(MAX_BYTES + 1);
  localparam int E_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int LT_W  = B_W + 3;

  vit_state_t           state;
  logic [B_W-1:0]       len;
  logic [B_W-1:0]       byte_cnt;
  logic [E_W-1:0]       emit_idx;
  logic [7:0]           rx0, rx1, rx2;
  logic [2:0]           bit_idx;
  logic [STATE_W-1:0]   st_idx;
  logic [T_W-1:0]       step;
  logic                 bank;
  logic [NUM_STATES-1:0] surv_row;
  logic [STATE_W-1:0]   tb_state;
  logic [PM_W-1:0]      best_pm;
  logic [STATE_W-1:0]   best_st;
  logic [STEPS-1:0]     dec_bits;

  logic [PM_W-1:0]      pm [2][NUM_STATES];
  logic [NUM_STATES-1:0] surv_mem [STEPS];

  logic [PM_W-1:0]      pm_new;
  logic                 surv;
  logic [2:0]           rx_triple;
  logic [LT_W-1:0]      last_t;
  logic                 last_step;
  logic                 upd_best;

  assign rx_triple = {rx2[bit_idx], rx1[bit_idx], rx0[bit_idx]};
  assign last_t    = {len, 3'b000} - LT_W'(1);
  assign last_step = (LT_W'(step) == last_t);
  assign upd_best  = last_step && ((st_idx == '0) || (pm_new < best_pm));

  vit_acs_unit #(.PM_W(PM_W)) u_acs (
    .next_state (st_idx),
    .rx         (rx_triple),
    .pm0        (pm[bank][{st_idx[4:0], 1'b0}]),
    .pm1        (pm[bank][{st_idx[4:0], 1'b1}]),
    .pm_new     (pm_new),
    .surv       (surv)
  );

  assign meta_rdreq = (state == ST_META);
  assign c_rdreq    = (state == ST_FETCH) && (c_empty == 3'b000);
  assign dec_wrreq  = (state == ST_EMIT) && !dec_full;
  assign dec_out    = (state == ST_EMIT) ? dec_bits[{emit_idx, 3'b000} +: 8] : 8'h00;
  assign busy       = (state != ST_IDLE);

  // Equal-start tail-biting approximation: every state begins the block at metric 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < NUM_STATES; s++)
          pm[b][s] <= '0;
    end else if (state == ST_META) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < NUM_STATES; s++)
          pm[b][s] <= '0;
    end else if (state == ST_ACS) begin
      pm[~bank][st_idx] <= pm_new;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_ACS && st_idx == 6'd63)
      surv_mem[step] <= {surv, surv_row[NUM_STATES-2:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      byte_cnt   <= '0;
      emit_idx   <= '0;
      rx0        <= '0;
      rx1        <= '0;
      rx2        <= '0;
      bit_idx    <= '0;
      st_idx     <= '0;
      step       <= '0;
      bank       <= 1'b0;
      surv_row   <= '0;
      tb_state   <= '0;
      best_pm    <= '0;
      best_st    <= '0;
      dec_bits   <= '0;
      block_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      block_done <= 1'b0;
      len_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!meta_empty) state <= ST_META;
        end
        ST_META: begin
          if (meta_in == 8'd0 || meta_in > 8'(MAX_BYTES)) begin
            len_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            len      <= B_W'(meta_in);
            byte_cnt <= '0;
            step     <= '0;
            bank     <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (c_empty == 3'b000) begin
            rx0      <= c0_in;
            rx1      <= c1_in;
            rx2      <= c2_in;
            bit_idx  <= '0;
            st_idx   <= '0;
            byte_cnt <= byte_cnt + B_W'(1);
            state    <= ST_ACS;
          end
        end
        ST_ACS: begin
          surv_row[st_idx] <= surv;
          if (upd_best) begin
            best_pm <= pm_new;
            best_st <= st_idx;
          end
          st_idx <= st_idx + 6'd1;
          if (st_idx == 6'd63) begin
            bank    <= ~bank;
            bit_idx <= bit_idx + 3'd1;
            if (last_step) begin
              // State 63 may itself be the winner; resolve it here rather than a cycle late.
              tb_state <= upd_best ? st_idx : best_st;
              state    <= ST_TB;
            end else begin
              step <= step + T_W'(1);
              if (bit_idx == 3'd7) state <= ST_FETCH;
            end
          end
        end
        ST_TB: begin
          dec_bits[step] <= tb_state[5];
          tb_state       <= {tb_state[4:0], surv_mem[step][tb_state]};
          if (step == '0) begin
            emit_idx <= '0;
            state    <= ST_EMIT;
          end else begin
            step <= step - T_W'(1);
          end
        end
        ST_EMIT: begin
          if (!dec_full) begin
            emit_idx <= emit_idx + E_W'(1);
            if (B_W'(emit_idx) == len - B_W'(1)) begin
              block_done <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_decoder_vit.sv
// Scoreboarded bench: an independent tail-biting encoder feeds FIFO models; a monitor checks decoded bytes.
module tb_conv_decoder_vit;
  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] meta_in;
  logic       meta_empty;
  logic       meta_rdreq;
  logic [7:0] c0_in, c1_in, c2_in;
  logic [2:0] c_empty;
  logic       c_rdreq;
  logic [7:0] dec_out;
  logic       dec_wrreq;
  logic       dec_full;
  logic       busy;
  logic       block_done;
  logic       len_err;

  always #5 clk = ~clk;

  conv_decoder_vit #(.MAX_BYTES(MAXB), .PM_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .meta_in    (meta_in),
    .meta_empty (meta_empty),
    .meta_rdreq (meta_rdreq),
    .c0_in      (c0_in),
    .c1_in      (c1_in),
    .c2_in      (c2_in),
    .c_empty    (c_empty),
    .c_rdreq    (c_rdreq),
    .dec_out    (dec_out),
    .dec_wrreq  (dec_wrreq),
    .dec_full   (dec_full),
    .busy       (busy),
    .block_done (block_done),
    .len_err    (len_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int lerr_cnt = 0;
  int c_pops   = 0;
  int wr_cnt   = 0;

  logic [7:0] meta_q[$];
  logic [7:0] c0_q[$];
  logic [7:0] c1_q[$];
  logic [7:0] c2_q[$];
  logic [7:0] exp_q[$];
  logic [6:0] gen [3];
  logic       pop_m = 1'b0;
  logic       pop_c = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic refresh_heads();
    meta_empty = (meta_q.size() == 0);
    meta_in    = meta_empty ? 8'h00 : meta_q[0];
    c_empty[0] = (c0_q.size() == 0);
    c_empty[1] = (c1_q.size() == 0);
    c_empty[2] = (c2_q.size() == 0);
    c0_in      = c_empty[0] ? 8'h00 : c0_q[0];
    c1_in      = c_empty[1] ? 8'h00 : c1_q[0];
    c2_in      = c_empty[2] ? 8'h00 : c2_q[0];
  endtask

  // Show-ahead FIFO models: pop requests sampled mid-cycle, applied just after the edge.
  always @(negedge clk) begin
    pop_m = meta_rdreq;
    pop_c = c_rdreq;
  end

  initial begin
    refresh_heads();
    forever begin
      @(posedge clk);
      #1;
      if (pop_m && meta_q.size() > 0) void'(meta_q.pop_front());
      if (pop_c) begin
        c_pops++;
        if (c0_q.size() > 0) void'(c0_q.pop_front());
        if (c1_q.size() > 0) void'(c1_q.pop_front());
        if (c2_q.size() > 0) void'(c2_q.pop_front());
      end
      refresh_heads();
    end
  end

  // Output monitor / scoreboard.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (dec_wrreq) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: actual byte %0h with nothing expected", dec_out);
          end else begin
            exp_b = exp_q.pop_front();
            check("dec_byte", 32'(dec_out), 32'(exp_b));
          end
        end
        if (dec_full) check("wrreq_while_full", 32'(dec_wrreq), 32'd0);
        if (block_done) done_cnt++;
        if (len_err) lerr_cnt++;
      end
    end
  end

  // Tail-biting encoder: tap j of generator k multiplies data bit i-6+j (mod block length).
  task automatic encode_push(input int L, input logic [7:0] d [MAXB], input int flip_period);
    logic [7:0] cb [3][MAXB];
    logic       bits [8*MAXB];
    logic       acc;
    int         n;
    int         st;
    n = 8 * L;
    for (int i = 0; i < n; i++) bits[i] = d[i/8][i%8];
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < MAXB; j++) cb[k][j] = 8'h00;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 3; k++) begin
        acc = 1'b0;
        for (int j = 0; j < 7; j++)
          if (gen[k][j]) acc = acc ^ bits[(i - 6 + j + n) % n];
        cb[k][i/8][i%8] = acc;
      end
    if (flip_period > 0)
      for (int f = flip_period / 2; f < 3 * n; f += flip_period) begin
        st = f / 3;
        cb[f%3][st/8][st%8] = ~cb[f%3][st/8][st%8];
      end
    meta_q.push_back(8'(L));
    for (int j = 0; j < L; j++) begin
      c0_q.push_back(cb[0][j]);
      c1_q.push_back(cb[1][j]);
      c2_q.push_back(cb[2][j]);
      exp_q.push_back(d[j]);
    end
  endtask

  task automatic run_block(input string name, input int L, input int flip_period, input bit zeros);
    logic [7:0] d [MAXB];
    int start_done;
    for (int j = 0; j < MAXB; j++) d[j] = zeros ? 8'h00 : 8'($urandom_range(0, 255));
    start_done = done_cnt;
    encode_push(L, d, flip_period);
    for (int c = 0; c < 6000 && done_cnt == start_done; c++) @(posedge clk);
    @(negedge clk);
    check({name, "_block_done"}, 32'(done_cnt - start_done), 32'd1);
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_meta_rdreq"}, 32'(meta_rdreq), 32'd0);
    check({tag, "_c_rdreq"}, 32'(c_rdreq), 32'd0);
    check({tag, "_dec_wrreq"}, 32'(dec_wrreq), 32'd0);
    check({tag, "_dec_out"}, 32'(dec_out), 32'd0);
    check({tag, "_block_done"}, 32'(block_done), 32'd0);
    check({tag, "_len_err"}, 32'(len_err), 32'd0);
  endtask

  initial begin
    logic [7:0] d [MAXB];
    int l0, p0, w0, s0;
    gen[0]   = 7'b1011011;
    gen[1]   = 7'b1111001;
    gen[2]   = 7'b1110101;
    dec_full = 1'b0;
    reset    = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    run_block("zeros_l4", 4, 0, 1'b1);
    run_block("rand_l8", 8, 0, 1'b0);
    run_block("errs_l8", 8, 24, 1'b0);

    // Illegal lengths must not touch the coded FIFOs.
    c0_q.push_back(8'hA5);
    c1_q.push_back(8'h5A);
    c2_q.push_back(8'h3C);
    l0 = lerr_cnt;
    p0 = c_pops;
    meta_q.push_back(8'd0);
    for (int c = 0; c < 50 && lerr_cnt == l0; c++) @(posedge clk);
    @(negedge clk);
    check("len0_idle", 32'(busy), 32'd0);
    meta_q.push_back(8'd9);
    for (int c = 0; c < 50 && lerr_cnt == l0 + 1; c++) @(posedge clk);
    @(negedge clk);
    check("len9_idle", 32'(busy), 32'd0);
    check("len_err_pulses", 32'(lerr_cnt - l0), 32'd2);
    check("len_err_no_c_pop", 32'(c_pops - p0), 32'd0);
    check("len_err_c_kept", 32'(c0_q.size()), 32'd1);
    c0_q.delete();
    c1_q.delete();
    c2_q.delete();
    repeat (2) @(posedge clk);

    // Output back-pressure: hold full for 20 cycles once emission has started.
    w0 = wr_cnt;
    fork
      run_block("stall_l8", 8, 0, 1'b0);
      begin
        for (int c = 0; c < 6000 && wr_cnt < w0 + 2; c++) @(posedge clk);
        #1 dec_full = 1'b1;
        repeat (20) @(posedge clk);
        #1 dec_full = 1'b0;
      end
    join
    check("stall_bytes_written", 32'(wr_cnt - w0), 32'd8);

    // Reset in the middle of the third byte's ACS pass.
    for (int j = 0; j < MAXB; j++) d[j] = 8'($urandom_range(0, 255));
    s0 = c_pops;
    encode_push(8, d, 0);
    for (int c = 0; c < 3000 && c_pops < s0 + 3; c++) @(posedge clk);
    repeat (100) @(posedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #3 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midblock_reset");
    meta_q.delete();
    c0_q.delete();
    c1_q.delete();
    c2_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    run_block("post_reset_l8", 8, 0, 1'b0);

    for (int b = 0; b < 3; b++) run_block("rand_len", $urandom_range(1, MAXB), 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_decoder_vit.md
# conv_decoder_vit

Hard-decision Viterbi decoder for the rate-1/3, K=7, tail-biting convolutional code (generators 133/171/165 octal) produced by the block encoder. It pops one meta byte (block length) and three coded byte streams from show-ahead FIFOs, decodes the block, and writes the recovered data bytes to an output FIFO. Serial add-compare-select (one trellis state per cycle), full-block survivor memory, single traceback from the best final state.

## Interface
- MAX_BYTES, 8: largest block in data bytes; survivor memory depth = 8*MAX_BYTES steps
- PM_W, 14: path-metric width; must satisfy 2^PM_W > 3*8*MAX_BYTES
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- meta_in  in  8  block length in data bytes (show-ahead FIFO head)
- meta_empty  in  1  meta FIFO empty
- meta_rdreq  out  1  pop meta FIFO
- c0_in, c1_in, c2_in  in  8 each  coded streams for g0/g1/g2 (FIFO heads)
- c_empty  in  3  empty flags of the three coded FIFOs, bit i = stream i
- c_rdreq  out  1  pops all three coded FIFOs together
- dec_out  out  8  decoded byte
- dec_wrreq  out  1  write strobe for dec_out
- dec_full  in  1  output FIFO full
- busy  out  1  high in any state other than IDLE
- block_done  out  1  one-cycle pulse after last byte written
- len_err  out  1  one-cycle pulse when meta is 0 or > MAX_BYTES

## Operation
- Trellis: state s[5:0] = last six inputs, s[5] newest. Next state n = {u, s[5:1]}. Code bits c_i = parity(g_i & {u,s}), g0=7'b1011011, g1=7'b1111001, g2=7'b1110101 (bit 6 multiplies u).
- Bit order: byte bit 0 is the first trellis step; coded stream bit k of byte j pairs with data bit k of byte j.
- FSM: IDLE -> META (meta_empty low) -> FETCH -> ACS -> (FETCH | TB) -> EMIT -> IDLE.
- META: pulse meta_rdreq, latch L. If L==0 or L>MAX_BYTES: pulse len_err, return to IDLE, no coded bytes consumed.
- Path metrics cleared to 0 (all states) at META: equal-start tail-biting approximation.
- FETCH: wait until c_empty==3'b000, latch three bytes, pulse c_rdreq one cycle.
- ACS: 8 steps x 64 states. For n: predecessors p0={n[4:0],0}, p1={n[4:0],1}, u=n[5]; branch metric = Hamming distance (0..3) between received triple and expected; new PM = min; survivor bit = 1 only if p1 path strictly smaller (ties -> p0). Metrics double-buffered; swap after state 63.
- During last step, track minimum final PM and its state (ties -> lowest index).
- TB: start at best state; per cycle output bit u=n[5] into byte buffer at step t, n <= {n[4:0], surv[t][n]}, t from 8L-1 down to 0.
- EMIT: write bytes 0..L-1, one per cycle while dec_full low; stall when high. block_done after byte L-1.
- No saturation needed; PM width rule guarantees no overflow.

## Timing
- Reset values: all outputs 0, FSM IDLE, metrics 0.
- rdreq pulses are single-cycle and combinationally independent of the same-cycle FIFO head change; data latched in the pulse cycle.
- Per byte: 1 FETCH cycle (minimum) + 512 ACS cycles. TB: 8L cycles. EMIT: L cycles minimum.
- Block latency from meta pop to first dec_wrreq with no stalls: 1 + 513L + 8L + 1 cycles.
- Reset low mid-block: immediate return to IDLE; partially consumed FIFO data is not restored.
- meta available during busy is ignored until IDLE.

## Structure
- Package conv_code_pkg: K, generator constants, STATE_W=6, FSM enum, expected-triple function (shared with encoder model).
- Sub-module vit_acs_unit: combinational branch metric plus compare-select for one next state; decoder instantiates one.
- Survivor memory as inferred RAM, 8*MAX_BYTES x 64.

## Test plan
- Encoder-model block L=4, data 0x00 x4 -> decoded 0x00,0x00,0x00,0x00, block_done once.
- L=8 random data, error-free coded streams -> decoded bytes equal source exactly.
- L=8, one flipped coded bit every 24 coded bits -> decoded equals source.
- meta=0 then meta=9 -> two len_err pulses, c_rdreq never asserted, IDLE after each.
- dec_full held high 20 cycles during EMIT -> dec_wrreq low throughout, bytes resume in order, none lost.
- Reset low during ACS of byte 2 -> all outputs 0 next cycle; following valid block decodes correctly.
